// File: rtl/cip_tx_sequencer.sv
// CIP header sequencer: opens transmissions, numbers their segments and emits one
// 64-bit header per accepted segment (or abort) through a one-deep output register.
module cip_tx_sequencer #(
    parameter logic [31:0] TID_INIT = 32'h0000_0001,
    parameter logic [15:0] MAX_SEQ  = 16'hFFFF
) (
    input  logic        axis_aclk,
    input  logic        axis_reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic        seg_valid,
    output logic        seg_ready,
    input  logic        seg_last,
    input  logic        seg_error,
    input  logic        abort,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [63:0] cip_hdr,
    output logic        busy,
    output logic [31:0] cur_tid
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]  state;
    logic [31:0] next_tid;
    logic [15:0] seq;

    logic        slot_free;
    logic        seg_fire;
    logic        abort_fire;
    logic        at_max;
    logic        hdr_last;
    logic        hdr_error;
    logic [31:0] tid_inc;

    assign start_ready = (state == ST_IDLE);
    assign busy        = (state == ST_ACTIVE);

    // The output register may be reloaded in the same cycle it is being drained.
    assign slot_free  = !hdr_valid || hdr_ready;
    assign seg_ready  = busy && slot_free && !abort;
    assign seg_fire   = seg_valid && seg_ready;
    assign abort_fire = busy && abort && slot_free;

    // Reaching MAX_SEQ always closes the transmission; a non-last segment there is an overflow.
    assign at_max    = (seq == MAX_SEQ);
    assign hdr_last  = abort_fire || seg_last || seg_error || at_max;
    assign hdr_error = abort_fire || seg_error || (at_max && !seg_last);

    assign tid_inc = next_tid + 32'd1;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order in this block.
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state     <= ST_IDLE;
            hdr_valid <= 1'b0;
            cip_hdr   <= 64'h0;
            cur_tid   <= 32'h0;
            next_tid  <= TID_INIT;
            seq       <= 16'h0;
        end else begin
            if (hdr_ready) begin
                hdr_valid <= 1'b0;
            end
            if (abort_fire || seg_fire) begin
                hdr_valid <= 1'b1;
                cip_hdr   <= {8'h00, seq, cur_tid, hdr_last, hdr_error, 6'h00};
            end

            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        cur_tid  <= next_tid;
                        // Transmission ID 0 is reserved, so the wrap lands on 1.
                        next_tid <= (tid_inc == 32'h0) ? 32'h1 : tid_inc;
                        seq      <= 16'h0;
                        state    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (abort_fire) begin
                        state <= ST_IDLE;
                    end else if (seg_fire) begin
                        if (hdr_last) begin
                            state <= ST_IDLE;
                        end else begin
                            seq <= seq + 16'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cip_tx_sequencer.sv
// Self-checking bench for cip_tx_sequencer: a queue-based transaction model predicts
// handshakes and headers; a second instance exercises MAX_SEQ and ID wrap limits.
module tb_cip_tx_sequencer;

    logic        clk = 1'b0;
    logic        axis_reset;
    logic        start_valid, seg_valid, seg_last, seg_error, abort, hdr_ready;

    logic        d0_start_ready, d0_seg_ready, d0_hdr_valid, d0_busy;
    logic [63:0] d0_cip_hdr;
    logic [31:0] d0_cur_tid;
    logic        d1_start_ready, d1_seg_ready, d1_hdr_valid, d1_busy;
    logic [63:0] d1_cip_hdr;
    logic [31:0] d1_cur_tid;

    logic        start_ready, seg_ready, hdr_valid, busy;
    logic [63:0] cip_hdr;
    logic [31:0] cur_tid;

    bit          sel;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    // Transaction-level model state
    bit          m_active;
    logic [31:0] m_cur, m_next, m_tid_init;
    logic [15:0] m_seq, m_max;
    logic [63:0] exp_q[$];
    logic [63:0] obs_log[$];

    always #5 clk = ~clk;

    cip_tx_sequencer dut_full (
        .axis_aclk(clk), .axis_reset(axis_reset),
        .start_valid(start_valid), .start_ready(d0_start_ready),
        .seg_valid(seg_valid), .seg_ready(d0_seg_ready),
        .seg_last(seg_last), .seg_error(seg_error), .abort(abort),
        .hdr_valid(d0_hdr_valid), .hdr_ready(hdr_ready), .cip_hdr(d0_cip_hdr),
        .busy(d0_busy), .cur_tid(d0_cur_tid)
    );

    cip_tx_sequencer #(.TID_INIT(32'hFFFF_FFFE), .MAX_SEQ(16'd3)) dut_small (
        .axis_aclk(clk), .axis_reset(axis_reset),
        .start_valid(start_valid), .start_ready(d1_start_ready),
        .seg_valid(seg_valid), .seg_ready(d1_seg_ready),
        .seg_last(seg_last), .seg_error(seg_error), .abort(abort),
        .hdr_valid(d1_hdr_valid), .hdr_ready(hdr_ready), .cip_hdr(d1_cip_hdr),
        .busy(d1_busy), .cur_tid(d1_cur_tid)
    );

    always_comb begin
        start_ready = sel ? d1_start_ready : d0_start_ready;
        seg_ready   = sel ? d1_seg_ready   : d0_seg_ready;
        hdr_valid   = sel ? d1_hdr_valid   : d0_hdr_valid;
        busy        = sel ? d1_busy        : d0_busy;
        cip_hdr     = sel ? d1_cip_hdr     : d0_cip_hdr;
        cur_tid     = sel ? d1_cur_tid     : d0_cur_tid;
    end

    function automatic logic [63:0] make_hdr(input logic [15:0] s, input logic [31:0] t,
                                             input logic l, input logic e);
        return {8'h00, s, t, l, e, 6'h00};
    endfunction

    task automatic drive(input bit sv, input bit gv, input bit gl, input bit ge,
                         input bit ab, input bit hr);
        start_valid = sv; seg_valid = gv; seg_last = gl;
        seg_error = ge; abort = ab; hdr_ready = hr;
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_cur    = 32'h0;
        m_next   = m_tid_init;
        m_seq    = 16'h0;
        exp_q.delete();
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        bit          free, exp_sr, exp_gr, exp_hv, at_max, l, e;
        logic [31:0] t;
        @(negedge clk);
        cyc++;
        free   = (exp_q.size() == 0) || hdr_ready;
        exp_sr = !m_active;
        exp_gr = m_active && free && !abort;
        exp_hv = (exp_q.size() != 0);
        n_checks += 5;
        if (start_ready !== exp_sr) begin
            n_fail++; $display("FAIL start_ready cyc=%0d got %b want %b", cyc, start_ready, exp_sr);
        end
        if (seg_ready !== exp_gr) begin
            n_fail++; $display("FAIL seg_ready cyc=%0d got %b want %b", cyc, seg_ready, exp_gr);
        end
        if (hdr_valid !== exp_hv) begin
            n_fail++; $display("FAIL hdr_valid cyc=%0d got %b want %b", cyc, hdr_valid, exp_hv);
        end
        if (busy !== m_active) begin
            n_fail++; $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, m_active);
        end
        if (cur_tid !== m_cur) begin
            n_fail++; $display("FAIL cur_tid cyc=%0d got %h want %h", cyc, cur_tid, m_cur);
        end
        if (exp_hv) begin
            n_checks++;
            if (cip_hdr !== exp_q[0]) begin
                n_fail++; $display("FAIL cip_hdr cyc=%0d got %h want %h", cyc, cip_hdr, exp_q[0]);
            end
        end
        if (hdr_valid && hdr_ready) obs_log.push_back(cip_hdr);

        @(posedge clk);
        if (exp_q.size() != 0 && hdr_ready) void'(exp_q.pop_front());
        if (!m_active) begin
            if (start_valid) begin
                m_cur    = m_next;
                m_next   = m_next + 32'd1;
                if (m_next == 32'h0) m_next = 32'h1;
                m_seq    = 16'h0;
                m_active = 1'b1;
            end
        end else if (abort) begin
            if (free) begin
                exp_q.push_back(make_hdr(m_seq, m_cur, 1'b1, 1'b1));
                m_active = 1'b0;
            end
        end else if (seg_valid && free) begin
            at_max = (m_seq == m_max);
            t = m_cur;
            l = seg_last || seg_error || at_max;
            e = seg_error || (at_max && !seg_last);
            exp_q.push_back(make_hdr(m_seq, t, l, e));
            if (l) m_active = 1'b0;
            else   m_seq = m_seq + 16'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        axis_reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        axis_reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        obs_log.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 6;
        if (hdr_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_hdr_valid got %b want 0", hdr_valid); end
        if (cip_hdr !== 64'h0)    begin n_fail++; $display("FAIL reset_cip_hdr got %h want 0", cip_hdr); end
        if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (cur_tid !== 32'h0)    begin n_fail++; $display("FAIL reset_cur_tid got %h want 0", cur_tid); end
        if (start_ready !== 1'b1) begin n_fail++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
        if (seg_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_seg_ready got %b want 0", seg_ready); end
    endtask

    task automatic test_basic();
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 1, 0, 0, 0, 1); step(); step();
        drive(0, 1, 1, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1); step(); step();
        n_checks += 4;
        if (obs_log.size() != 3) begin
            n_fail++; $display("FAIL basic_count got %0d want 3", obs_log.size());
        end else begin
            if (obs_log[0] !== make_hdr(16'd0, 32'd1, 1'b0, 1'b0)) begin n_fail++; $display("FAIL basic_hdr0 got %h", obs_log[0]); end
            if (obs_log[1] !== make_hdr(16'd1, 32'd1, 1'b0, 1'b0)) begin n_fail++; $display("FAIL basic_hdr1 got %h", obs_log[1]); end
            if (obs_log[2] !== make_hdr(16'd2, 32'd1, 1'b1, 1'b0)) begin n_fail++; $display("FAIL basic_hdr2 got %h", obs_log[2]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 1, 1, 0, 0, 1); step();
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 1, 0, 0, 0, 1); step();
        drive(0, 1, 1, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1); step(); step();
        n_checks += 3;
        if (cur_tid !== 32'd2) begin n_fail++; $display("FAIL b2b_cur_tid got %h want 2", cur_tid); end
        if (obs_log.size() != 3) begin
            n_fail++; $display("FAIL b2b_count got %0d want 3", obs_log.size());
        end else if (obs_log[1] !== make_hdr(16'd0, 32'd2, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL b2b_first_of_second got %h", obs_log[1]);
        end
    endtask

    task automatic test_backpressure();
        int base;
        base = obs_log.size();
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 1, 0, 0, 0, 1); step();
        drive(0, 1, 0, 0, 0, 0); repeat (4) step();
        drive(0, 1, 0, 0, 0, 1); step(); step();
        drive(0, 1, 1, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1); step(); step();
        n_checks++;
        if (obs_log.size() - base != 4) begin
            n_fail++; $display("FAIL bp_count got %0d want 4", obs_log.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (obs_log[base+i][55:40] !== 16'(i)) begin
                    n_fail++; $display("FAIL bp_seq%0d got %0d want %0d", i, obs_log[base+i][55:40], i);
                end
            end
        end
    endtask

    task automatic test_error();
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 1, 0, 0, 0, 1); repeat (5) step();
        drive(0, 1, 0, 1, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1); step(); step();
        n_checks++;
        if (obs_log[$] !== make_hdr(16'd5, m_cur, 1'b1, 1'b1)) begin
            n_fail++; $display("FAIL err_hdr got %h want %h", obs_log[$], make_hdr(16'd5, m_cur, 1'b1, 1'b1));
        end
    endtask

    task automatic test_abort();
        int base;
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 1, 0, 0, 0, 1); step(); step();
        drive(0, 1, 0, 0, 1, 1); step();
        drive(0, 0, 0, 0, 0, 1); step(); step();
        n_checks++;
        if (obs_log[$] !== make_hdr(16'd2, m_cur, 1'b1, 1'b1)) begin
            n_fail++; $display("FAIL abort_hdr got %h want %h", obs_log[$], make_hdr(16'd2, m_cur, 1'b1, 1'b1));
        end
        base = obs_log.size();
        drive(0, 1, 0, 0, 1, 1); repeat (3) step();
        drive(0, 0, 0, 0, 0, 1); step();
        n_checks++;
        if (obs_log.size() != base) begin
            n_fail++; $display("FAIL abort_idle_out got %0d headers want 0", obs_log.size() - base);
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(1, 0) == 1, $urandom_range(9, 0) < 7, $urandom_range(9, 0) == 0,
                  $urandom_range(19, 0) == 0, $urandom_range(19, 0) == 0, $urandom_range(9, 0) < 7);
            step();
        end
        drive(0, 0, 0, 0, 1, 1); step(); step();
        drive(0, 0, 0, 0, 0, 1); step();
    endtask

    task automatic test_overflow();
        int base;
        sel = 1'b1; m_max = 16'd3; m_tid_init = 32'hFFFF_FFFE;
        do_reset();
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 1, 0, 0, 0, 1); repeat (6) step();
        n_checks += 2;
        if (obs_log.size() != 4) begin
            n_fail++; $display("FAIL ovf_count got %0d want 4", obs_log.size());
        end else if (obs_log[3] !== make_hdr(16'd3, 32'hFFFF_FFFE, 1'b1, 1'b1)) begin
            n_fail++; $display("FAIL ovf_last_hdr got %h", obs_log[3]);
        end
        if (seg_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_seg_held got %b want 0", seg_ready); end
        base = obs_log.size();
        drive(1, 1, 0, 0, 0, 1); step();
        drive(0, 1, 1, 0, 0, 1); step();
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1); step();
        n_checks += 2;
        if (obs_log[base] !== make_hdr(16'd0, 32'hFFFF_FFFF, 1'b1, 1'b0)) begin
            n_fail++; $display("FAIL ovf_restart_hdr got %h", obs_log[base]);
        end
        if (cur_tid !== 32'h1) begin n_fail++; $display("FAIL tid_wrap got %h want 00000001", cur_tid); end
        drive(0, 1, 1, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1); step();
        test_random(1500);
    endtask

    task automatic test_reset_midflight();
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 1, 0, 0, 0, 0); step(); step();
        #2;
        axis_reset = 1'b1;
        #1;
        n_checks += 2;
        if (hdr_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid got %b want 0", hdr_valid); end
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL async_reset_busy got %b want 0", busy); end
        do_reset();
        drive(1, 0, 0, 0, 0, 1); step();
        drive(0, 0, 0, 0, 0, 1); step();
        n_checks++;
        if (cur_tid !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL tid_after_reset got %h want fffffffe", cur_tid);
        end
    endtask

    initial begin
        sel = 1'b0; m_max = 16'hFFFF; m_tid_init = 32'h0000_0001;
        axis_reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_error();
        test_abort();
        test_random(2000);
        test_overflow();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cip_tx_sequencer.md
Name: cip_tx_sequencer

Overview:
- Sequences CIP header generation for outgoing image transmissions.
- Allocates a transmission ID per transmission and numbers its segments.
- Sets last/error flags, including on abort or sequence overflow.
- Emits one 64-bit CIP header per segment over a valid/ready handshake to the packet assembler; sits between the image segmenter and the header insertion stage.

Parameters:
- TID_INIT, 32'h0000_0001: transmission ID assigned to the first transmission after reset.
- MAX_SEQ, 16'hFFFF: highest legal sequence number within one transmission.

Ports:
- axis_aclk  in  1  clock
- axis_reset  in  1  asynchronous, active-high reset
- start_valid  in  1  request to open a new transmission
- start_ready  out  1  sequencer can accept a start (IDLE)
- seg_valid  in  1  segment header request
- seg_ready  out  1  segment accepted this cycle when seg_valid && seg_ready
- seg_last  in  1  segment is final of the transmission
- seg_error  in  1  segment carries an error; terminates the transmission
- abort  in  1  terminate the active transmission
- hdr_valid  out  1  cip_hdr holds a valid header
- hdr_ready  in  1  downstream accepts the header
- cip_hdr  out  64  [7]=last, [6]=error, [5:0]=0, [39:8]=transmission ID, [55:40]=sequence number, [63:56]=0 (retry number)
- busy  out  1  state is ACTIVE
- cur_tid  out  32  ID of the current or most recent transmission

Behaviour:
- Clock and reset: one clock domain (axis_aclk). Reset is asynchronous, active-high (axis_reset).
- Reset values:
  - state=IDLE, hdr_valid=0, cip_hdr=0, busy=0, cur_tid=0.
  - Internal next_tid=TID_INIT, seq=0.
  - start_ready=1 and seg_ready=0, both decoded from state.
- States:
  - IDLE: start_ready=1, seg_ready=0, abort ignored.
    - start_valid → cur_tid<=next_tid, next_tid<=next_tid+1 (32-bit wrap; value 0 skipped → 1), seq<=0, go ACTIVE.
  - ACTIVE: start_ready=0, busy=1.
    - slot_free = !hdr_valid || hdr_ready.
    - seg_ready = slot_free && !abort.
- Segment acceptance (ACTIVE, seg_valid && seg_ready):
  - Next cycle: hdr_valid=1, cip_hdr = {8'h0, seq, cur_tid, last, error, 6'h0}; latency 1 cycle.
  - error = seg_error.
  - last = seg_last || seg_error || (seq==MAX_SEQ).
  - error is also forced to 1 when seq==MAX_SEQ && !seg_last (overflow).
  - If last=1 → IDLE; else seq<=seq+1.
- Abort (ACTIVE, abort=1):
  - Takes priority over seg_valid in the same cycle; no segment is accepted.
  - When slot_free: emit header {seq, cur_tid, last=1, error=1}, go IDLE.
  - If the slot is not free, abort must be held; the sequencer emits on the first slot_free cycle with abort=1.
- Output handshake:
  - cip_hdr and hdr_valid are registered and stable while hdr_valid && !hdr_ready.
  - Acceptance with a simultaneous new segment reloads the register (back-to-back, 1 header/cycle).
  - hdr_valid drops only on hdr_ready with no new load.
- IDLE with a header still pending: start is accepted. The new transmission's first segment waits on slot_free; no header is overwritten.
- Wrap: seq never exceeds MAX_SEQ; the transmission is always terminated at MAX_SEQ.
- Reset mid-operation: the pending header is discarded at once (hdr_valid→0 asynchronously) and all state returns to the reset values, including next_tid=TID_INIT.
- seg_last/seg_error are sampled only on acceptance.

Test Plan:
1. Reset, start, 3 segments (third with seg_last), hdr_ready=1 → headers with tid=1, seq=0,1,2, flags 00,00,10 (last,error); then busy=0, start_ready=1.
2. Two transmissions back-to-back → second tid=2, seq restarts at 0; cur_tid=2.
3. hdr_ready=0 for 4 cycles with seg_valid high → seg_ready=0, cip_hdr stable; on hdr_ready=1, one header per cycle with no loss or duplication.
4. Segment with seg_error=1, seg_last=0 at seq=5 → header seq=5, last=1, error=1; state IDLE.
5. Abort asserted together with seg_valid at seq=2 → segment not accepted; header seq=2, last=1, error=1. Abort in IDLE → no output.
6. MAX_SEQ=3, 5 non-last segments → seq 0..3 emitted, seq=3 with last=1/error=1, fifth segment not accepted until a new start. Assert axis_reset while hdr_valid=1 → hdr_valid=0 immediately; next tid=TID_INIT.
